hilo_mul_unit: RTL and testbench

- Execute-side consumer of the decode-stage issue bundle (aluop, reg1, reg2); owns the HI/LO register pair.
- Executes MULT/MULTU as an iterative shift-add multiply, holding the pipeline through a stall request while it runs.
- Serves MTHI/MTLO writes and MFHI/MFLO reads.
- Sits beside the EX ALU; its stall request feeds pipeline control.

---
 rtl/hilo_mul_unit.sv | 178 +++++++++++++++++
 tb/tb_hilo_mul_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_unit.sv
// HI/LO register pair with an iterative shift-add MULT/MULTU engine and MTHI/MTLO/MFHI/MFLO support.
// Define HILO_MUL_RADIX4_EN to retire two multiplier bits per RUN cycle instead of one.
module hilo_mul_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              annul_i,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] mf_data_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);
`ifdef HILO_MUL_RADIX4_EN
  localparam int STEPS = DATA_W / 2;
`else
  localparam int STEPS = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  counter;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [PROD_W-1:0] acc;
  logic              neg;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
`ifdef HILO_MUL_RADIX4_EN
  logic [PROD_W-1:0] mcand3;
`endif

  logic              is_mult;
  logic              is_multu;
  logic              issue_ok;
  logic              start;
  logic              mt_hi;
  logic              mt_lo;
  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;
  logic [PROD_W-1:0] op1_wide;
  logic [PROD_W-1:0] partial;
  logic [PROD_W-1:0] product;

  // Decode of the issue bundle; new work is only accepted while IDLE and never under reset.
  always_comb begin
    is_mult  = (aluop_i == EXE_MULT_OP);
    is_multu = (aluop_i == EXE_MULTU_OP);
    issue_ok = valid_i && !annul_i && !rst && (state == IDLE);
    start    = issue_ok && (is_mult || is_multu);
    mt_hi    = issue_ok && (aluop_i == EXE_MTHI_OP);
    mt_lo    = issue_ok && (aluop_i == EXE_MTLO_OP);
  end

  // Signed MULT runs on magnitudes; negating 0x80000000 yields 0x80000000, read as unsigned.
  always_comb begin
    op1_mag  = (is_mult && reg1_i[DATA_W-1]) ? (~reg1_i + 1'b1) : reg1_i;
    op2_mag  = (is_mult && reg2_i[DATA_W-1]) ? (~reg2_i + 1'b1) : reg2_i;
    op1_wide = {{DATA_W{1'b0}}, op1_mag};
  end

  always_comb begin
    partial = '0;
`ifdef HILO_MUL_RADIX4_EN
    case (mplier[1:0])
      2'b01:   partial = mcand;
      2'b10:   partial = mcand << 1;
      2'b11:   partial = mcand3;
      default: partial = '0;
    endcase
`else
    if (mplier[0]) partial = mcand;
`endif
  end

  always_comb begin
    product = neg ? (~acc + 1'b1) : acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (annul_i)                     state_nxt = IDLE;
        else if (counter == LAST_STEP)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Multiplier datapath: operands latched on start, one (or two) bits retired per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
`ifdef HILO_MUL_RADIX4_EN
      mcand3  <= '0;
`endif
    end else begin
      if (start) begin
        counter <= '0;
        mcand   <= op1_wide;
        mplier  <= op2_mag;
        acc     <= '0;
        neg     <= is_mult && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
`ifdef HILO_MUL_RADIX4_EN
        mcand3  <= (op1_wide << 1) + op1_wide;
`endif
      end else if (state == RUN) begin
        acc     <= acc + partial;
        counter <= counter + 1'b1;
`ifdef HILO_MUL_RADIX4_EN
        mcand   <= mcand << 2;
        mcand3  <= mcand3 << 2;
        mplier  <= mplier >> 2;
`else
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
`endif
      end
    end
  end

  // DONE and MT* are mutually exclusive because MT* only issues from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if ((state == DONE) && !annul_i) begin
      hi <= product[PROD_W-1:DATA_W];
      lo <= product[DATA_W-1:0];
    end else begin
      if (mt_hi) hi <= reg1_i;
      if (mt_lo) lo <= reg1_i;
    end
  end

  always_comb begin
    stallreq_o = start || ((state == RUN) && !annul_i);
    busy_o     = (state != IDLE);
    hi_o       = hi;
    lo_o       = lo;
    mf_data_o  = '0;
    if (valid_i && (aluop_i == EXE_MFHI_OP)) mf_data_o = hi;
    if (valid_i && (aluop_i == EXE_MFLO_OP)) mf_data_o = lo;
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Self-checking bench for hilo_mul_unit: directed corner cases plus randomized MULT/MULTU/MT/MF traffic
// checked against a plain-arithmetic HI/LO model. Honours HILO_MUL_RADIX4_EN for the expected stall length.
module tb_hilo_mul_unit;

  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
`ifdef HILO_MUL_RADIX4_EN
  localparam int STALL_CYCLES = 17;
`else
  localparam int STALL_CYCLES = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  aluop;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        annul;
  logic        stallreq;
  logic [31:0] mfData;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        busy;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] modelHi    = '0;
  logic [31:0] modelLo    = '0;

  hilo_mul_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid),
    .aluop_i   (aluop),
    .reg1_i    (reg1),
    .reg2_i    (reg2),
    .annul_i   (annul),
    .stallreq_o(stallreq),
    .mf_data_o (mfData),
    .hi_o      (hiOut),
    .lo_o      (loOut),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic an);
    valid = v;
    aluop = op;
    reg1  = a;
    reg2  = b;
    annul = an;
  endtask

  function automatic logic [63:0] refProduct(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (op == OP_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // Issue a multiply at the start of a cycle and follow it until the stall drops and HI/LO land.
  task automatic doMul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int          stalls = 0;
    logic        done   = 1'b0;
    logic [63:0] p;
    applyStimulus(1'b1, op, a, b, 1'b0);
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      if (stallreq) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checkOutput("mul_timeout", 64'd0, 64'd1);
    end else begin
      checkOutput("busy_in_done", 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1 applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
    p       = refProduct(op, a, b);
    modelHi = p[63:32];
    modelLo = p[31:0];
    @(negedge clk);
    checkOutput("stall_len", 64'(stalls), 64'(STALL_CYCLES));
    checkOutput("mul_hi", 64'(hiOut), 64'(modelHi));
    checkOutput("mul_lo", 64'(loOut), 64'(modelLo));
    checkOutput("busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic doMove(input logic [7:0] op, input logic [31:0] val, input logic an);
    applyStimulus(1'b1, op, val, $urandom, an);
    @(negedge clk);
    checkOutput("mt_no_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    if (!an && op == OP_MTHI) modelHi = val;
    if (!an && op == OP_MTLO) modelLo = val;
    #1 applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
  endtask

  task automatic doRead(input logic [7:0] op, input logic v, input logic [31:0] expected, input string tag);
    applyStimulus(v, op, $urandom, $urandom, 1'b0);
    @(negedge clk);
    checkOutput(tag, 64'(mfData), 64'(expected));
    checkOutput("mf_no_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hi", 64'(hiOut), 64'd0);
    checkOutput("rst_lo", 64'(loOut), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_stall", 64'(stallreq), 64'd0);
    checkOutput("rst_mf", 64'(mfData), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    doMul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("plan_multu_hi", 64'(hiOut), 64'h0000_0000_FFFF_FFFE);
    checkOutput("plan_multu_lo", 64'(loOut), 64'h0000_0000_0000_0001);
    doMul(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    checkOutput("plan_neg_hi", 64'(hiOut), 64'h0000_0000_FFFF_FFFF);
    checkOutput("plan_neg_lo", 64'(loOut), 64'h0000_0000_FFFF_FFEB);
    doMul(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    checkOutput("plan_min2_hi", 64'(hiOut), 64'h0000_0000_4000_0000);
    doMul(OP_MULT, 32'h8000_0000, 32'h0000_0001);
    checkOutput("plan_min1_lo", 64'(loOut), 64'h0000_0000_8000_0000);
    doMul(OP_MULTU, 32'h0, 32'h1234_5678);

    doMove(OP_MTHI, 32'h1234_5678, 1'b0);
    doMove(OP_MTLO, 32'h9ABC_DEF0, 1'b0);
    doRead(OP_MFHI, 1'b1, 32'h1234_5678, "mfhi");
    doRead(OP_MFLO, 1'b1, 32'h9ABC_DEF0, "mflo");
    doRead(OP_ADD, 1'b1, 32'h0, "mf_other_op");
    doRead(OP_MFHI, 1'b0, 32'h0, "mf_not_valid");
    doMove(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
    doRead(OP_MFHI, 1'b1, modelHi, "mthi_annulled");

    // Annul a MULTU in its 10th RUN cycle; HI/LO must keep the MT values above.
    applyStimulus(1'b1, OP_MULTU, 32'd5, 32'd6, 1'b0);
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    checkOutput("annul_stall_drop", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("annul_busy", 64'(busy), 64'd0);
    checkOutput("annul_hi_kept", 64'(hiOut), 64'(modelHi));
    checkOutput("annul_lo_kept", 64'(loOut), 64'(modelLo));
    @(posedge clk);
    #1;
    doMul(OP_MULTU, 32'd5, 32'd6);
    checkOutput("after_annul_lo", 64'(loOut), 64'd30);

    applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    checkOutput("idle_annul_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("idle_annul_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      doMul(op, a, b);
      if (i % 4 == 0) doMove(OP_MTLO, $urandom, 1'b0);
      doRead(OP_MFHI, 1'b1, modelHi, "rand_mfhi");
      doRead(OP_MFLO, 1'b1, modelLo, "rand_mflo");
    end

    // Asynchronous reset in the middle of RUN, with the MULT still presented on the bus.
    doMove(OP_MTHI, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b1, OP_MULT, 32'h7, 32'h3, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrun_rst_hi", 64'(hiOut), 64'd0);
    checkOutput("midrun_rst_lo", 64'(loOut), 64'd0);
    checkOutput("midrun_rst_busy", 64'(busy), 64'd0);
    checkOutput("midrun_rst_stall", 64'(stallreq), 64'd0);
    applyStimulus(1'b0, 8'h00, '0, '0, 1'b0);
    modelHi = '0;
    modelLo = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    doMul(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
